// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: row-pointer FSM state encoding and data-width defaults.
package spmv_pkg;

  // Default width of CSR row pointers and per-row nnz counts.
  localparam int PTR_W_DEFAULT = 32;

  // Width of the row counter and of the running nnz total.
  localparam int ROW_CNT_W = 32;

  // Row-pointer to nnz-count generator states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } nnz_state_t;

endpackage

// File: rtl/row_nnz_gen_if.sv
// Stream bundle for row_nnz_gen: CSR row-pointer input stream and per-row
// nnz-count (TIMES) output stream. The slave modport is the generator side.
interface row_nnz_gen_if
  import spmv_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEFAULT
);

  logic [PTR_W-1:0] S_AXIS_ROWPTR_tdata;
  logic             S_AXIS_ROWPTR_tvalid;
  logic             S_AXIS_ROWPTR_tready;

  logic [PTR_W-1:0] M_AXIS_TIMES_tdata;
  logic             M_AXIS_TIMES_tvalid;
  logic             M_AXIS_TIMES_tready;

  modport slave (
    input  S_AXIS_ROWPTR_tdata,
    input  S_AXIS_ROWPTR_tvalid,
    output S_AXIS_ROWPTR_tready,
    output M_AXIS_TIMES_tdata,
    output M_AXIS_TIMES_tvalid,
    input  M_AXIS_TIMES_tready
  );

  modport master (
    output S_AXIS_ROWPTR_tdata,
    output S_AXIS_ROWPTR_tvalid,
    input  S_AXIS_ROWPTR_tready,
    input  M_AXIS_TIMES_tdata,
    input  M_AXIS_TIMES_tvalid,
    output M_AXIS_TIMES_tready
  );

endinterface

// File: rtl/row_nnz_out_reg.sv
// One-deep valid/ready output register. Accepts a new word whenever it is
// empty or its current word leaves this cycle, so a continuously ready sink
// sees one word per cycle; a stalled word is held unchanged.
module row_nnz_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load or hand off the buffered word; hold it while the sink stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/row_nnz_gen.sv
// Converts a CSR row-pointer stream into per-row nnz counts (difference of
// consecutive pointers). A job consumes Row_Count+1 pointers and emits
// Row_Count counts; a decreasing pointer emits 0 and sets a sticky error.
// Optional feature macro ROW_NNZ_TOTAL_EN: when defined, Total_Nnz keeps a
// running sum of counts accepted downstream; otherwise it is tied to 0.
module row_nnz_gen
  import spmv_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  row_nnz_gen_if.slave         axis,
  input  logic                 Start,
  input  logic [ROW_CNT_W-1:0] Row_Count,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err_Nonmono,
  output logic [ROW_CNT_W-1:0] Total_Nnz
);

  nnz_state_t           state;
  logic [ROW_CNT_W-1:0] rows_left;
  logic [PTR_W-1:0]     prev_ptr;
  logic [PTR_W-1:0]     cur_ptr;
  logic [PTR_W-1:0]     row_nnz;
  logic                 ptr_dec;
  logic                 in_ready;
  logic                 src_ready;
  logic                 in_fire;
  logic                 out_load;
  logic                 drain_ok;

  assign cur_ptr = axis.S_AXIS_ROWPTR_tdata;
  assign ptr_dec = cur_ptr < prev_ptr;
  assign row_nnz = ptr_dec ? '0 : (cur_ptr - prev_ptr);
  assign in_fire = src_ready && axis.S_AXIS_ROWPTR_tvalid;
  assign out_load = (state == ST_RUN) && in_fire;
  assign drain_ok = !axis.M_AXIS_TIMES_tvalid || axis.M_AXIS_TIMES_tready;
  assign Busy = (state != ST_IDLE);
  assign axis.S_AXIS_ROWPTR_tready = src_ready;

  // Input-side ready: always open for the first pointer, back-pressured by the output register while running, closed otherwise.
  always_comb begin
    src_ready = 1'b0;
    case (state)
      ST_FIRST: src_ready = 1'b1;
      ST_RUN:   src_ready = in_ready;
      default:  src_ready = 1'b0;
    endcase
  end

  row_nnz_out_reg #(
    .W(PTR_W)
  ) u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (out_load),
    .in_data  (row_nnz),
    .in_ready (in_ready),
    .out_valid(axis.M_AXIS_TIMES_tvalid),
    .out_data (axis.M_AXIS_TIMES_tdata),
    .out_ready(axis.M_AXIS_TIMES_tready)
  );

  // Job sequencing: latch the row count, track the previous pointer, flag decreases, and pulse Done once the output is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      rows_left   <= '0;
      prev_ptr    <= '0;
      Done        <= 1'b0;
      Err_Nonmono <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            rows_left   <= Row_Count;
            Err_Nonmono <= 1'b0;
            state       <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (in_fire) begin
            prev_ptr <= cur_ptr;
            state    <= (rows_left != '0) ? ST_RUN : ST_DRAIN;
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            prev_ptr  <= cur_ptr;
            rows_left <= rows_left - 1'b1;
            if (ptr_dec) begin
              Err_Nonmono <= 1'b1;
            end
            if (rows_left == {{(ROW_CNT_W-1){1'b0}}, 1'b1}) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            Done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROW_NNZ_TOTAL_EN
  logic out_fire;
  assign out_fire = axis.M_AXIS_TIMES_tvalid && axis.M_AXIS_TIMES_tready;

  // Running total of counts as they leave downstream; cleared when a job starts, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      Total_Nnz <= '0;
    end else if ((state == ST_IDLE) && Start) begin
      Total_Nnz <= '0;
    end else if (out_fire) begin
      Total_Nnz <= Total_Nnz + ROW_CNT_W'(axis.M_AXIS_TIMES_tdata);
    end
  end
`else
  assign Total_Nnz = '0;
`endif

endmodule

// File: tb/tb_row_nnz_gen.sv
// Self-checking bench for row_nnz_gen: directed jobs, a pointer-difference
// model feeding an expected-output queue, and per-cycle stream checks.
module tb_row_nnz_gen;

  localparam int PTR_W = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Row_Count = '0;
  logic        Busy;
  logic        Done;
  logic        Err_Nonmono;
  logic [31:0] Total_Nnz;

  row_nnz_gen_if #(.PTR_W(PTR_W)) bus ();

  row_nnz_gen #(.PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .axis       (bus),
    .Start      (Start),
    .Row_Count  (Row_Count),
    .Busy       (Busy),
    .Done       (Done),
    .Err_Nonmono(Err_Nonmono),
    .Total_Nnz  (Total_Nnz)
  );

  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          cyc = 0;
  int          first_out_cyc = 0;
  int          last_out_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          stall_mode = 1'b0;
  bit          sink_phase = 1'b1;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_data = '0;
  bit          exp_err;
  logic [31:0] exp_total;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total_checks++;
    if (act !== req) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: each count is the difference of adjacent pointers, 0 when negative.
  task automatic buildModel(input logic [31:0] ptrs[$]);
    longint d;
    exp_err   = 1'b0;
    exp_total = '0;
    for (int i = 1; i < ptrs.size(); i++) begin
      d = longint'(ptrs[i]) - longint'(ptrs[i-1]);
      if (d < 0) begin
        d = 0;
        exp_err = 1'b1;
      end
      exp_q.push_back(32'(d));
      exp_total = exp_total + 32'(d);
    end
  endtask

  // Source and sink drivers: inputs change 1 time unit after the rising edge.
  initial begin
    bit src_fire;
    bus.S_AXIS_ROWPTR_tvalid = 1'b0;
    bus.S_AXIS_ROWPTR_tdata  = '0;
    bus.M_AXIS_TIMES_tready  = 1'b0;
    forever begin
      @(negedge clk);
      src_fire = rstn && bus.S_AXIS_ROWPTR_tvalid && bus.S_AXIS_ROWPTR_tready;
      @(posedge clk);
      #1;
      if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
      bus.S_AXIS_ROWPTR_tvalid = (src_q.size() > 0);
      bus.S_AXIS_ROWPTR_tdata  = (src_q.size() > 0) ? src_q[0] : 32'd0;
      bus.M_AXIS_TIMES_tready  = stall_mode ? sink_phase : 1'b1;
      sink_phase = !sink_phase;
    end
  end

  // Compare process: sampled on the falling edge, every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        prev_stalled = 1'b0;
      end else begin
        if (Done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_stalled) begin
          checkOutput("hold_valid", 64'(bus.M_AXIS_TIMES_tvalid), 64'd1);
          checkOutput("hold_data", 64'(bus.M_AXIS_TIMES_tdata), 64'(prev_data));
        end
        if (bus.M_AXIS_TIMES_tvalid && !bus.M_AXIS_TIMES_tready)
          checkOutput("src_blocked", 64'(bus.S_AXIS_ROWPTR_tready), 64'd0);
        if (bus.M_AXIS_TIMES_tvalid && bus.M_AXIS_TIMES_tready) begin
          if (got_q.size() == 0) first_out_cyc = cyc;
          got_q.push_back(bus.M_AXIS_TIMES_tdata);
          last_out_cyc = cyc;
          if (exp_q.size() == 0) begin
            total_checks++;
            bad_checks++;
            $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", bus.M_AXIS_TIMES_tdata);
          end else begin
            checkOutput("times_data", 64'(bus.M_AXIS_TIMES_tdata), 64'(exp_q.pop_front()));
          end
        end
        prev_stalled = bus.M_AXIS_TIMES_tvalid && !bus.M_AXIS_TIMES_tready;
        prev_data    = bus.M_AXIS_TIMES_tdata;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] ptrs[$], input logic [31:0] rc, input bit busy_start);
    got_q.delete();
    done_cnt = 0;
    buildModel(ptrs);
    @(posedge clk); #2;
    Start = 1'b1;
    Row_Count = rc;
    foreach (ptrs[i]) src_q.push_back(ptrs[i]);
    @(posedge clk); #2;
    Start = 1'b0;
    Row_Count = 32'hDEAD_BEEF;
    checkOutput("busy_on_start", 64'(Busy), 64'd1);
    checkOutput("err_clr_on_start", 64'(Err_Nonmono), 64'd0);
    checkOutput("total_clr_on_start", 64'(Total_Nnz), 64'd0);
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #2;
      Start = 1'b1;
      Row_Count = 32'd7;
      @(posedge clk); #2;
      Start = 1'b0;
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    if (done_cnt == 0) begin
      total_checks++;
      bad_checks++;
      $display("[TB] FAIL done_timeout: got no Done, expected one within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic checkJob(input logic [31:0] lit[$], input bit lit_err, input logic [31:0] lit_total, input bit chk_lat);
    checkOutput("done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("busy_after", 64'(Busy), 64'd0);
    checkOutput("src_consumed", 64'(src_q.size()), 64'd0);
    checkOutput("model_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("beat_count", 64'(got_q.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size() && i < got_q.size(); i++)
      checkOutput("literal_beat", 64'(got_q[i]), 64'(lit[i]));
    checkOutput("err_flag", 64'(Err_Nonmono), 64'(lit_err));
    checkOutput("model_err", 64'(exp_err), 64'(lit_err));
`ifdef ROW_NNZ_TOTAL_EN
    checkOutput("total_nnz", 64'(Total_Nnz), 64'(lit_total));
    checkOutput("model_total", 64'(exp_total), 64'(lit_total));
`else
    checkOutput("total_nnz", 64'(Total_Nnz), 64'd0);
`endif
    if (chk_lat) checkOutput("done_latency", 64'(done_cyc - last_out_cyc), 64'd1);
  endtask

  // Main sequence of directed jobs.
  initial begin
    logic [31:0] p[$];
    logic [31:0] lit[$];

    #2;
    checkOutput("rst_src_ready", 64'(bus.S_AXIS_ROWPTR_tready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.M_AXIS_TIMES_tvalid), 64'd0);
    checkOutput("rst_out_data", 64'(bus.M_AXIS_TIMES_tdata), 64'd0);
    checkOutput("rst_busy", 64'(Busy), 64'd0);
    checkOutput("rst_done", 64'(Done), 64'd0);
    checkOutput("rst_err", 64'(Err_Nonmono), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;

    $display("[TB] basic stream, sink always ready");
    p = '{32'd0, 32'd3, 32'd3, 32'd7, 32'd12};
    lit = '{32'd3, 32'd0, 32'd4, 32'd5};
    applyStimulus(p, 32'd4, 1'b0);
    waitDone();
    checkJob(lit, 1'b0, 32'd12, 1'b1);
    checkOutput("throughput", 64'(last_out_cyc - first_out_cyc), 64'd3);

    $display("[TB] same stream, sink toggling, Start pulsed while busy");
    stall_mode = 1'b1;
    sink_phase = 1'b1;
    applyStimulus(p, 32'd4, 1'b1);
    waitDone();
    checkJob(lit, 1'b0, 32'd12, 1'b1);
    stall_mode = 1'b0;

    $display("[TB] zero-row job");
    p = '{32'd5};
    lit = '{};
    applyStimulus(p, 32'd0, 1'b0);
    waitDone();
    checkJob(lit, 1'b0, 32'd0, 1'b0);

    $display("[TB] decreasing pointer");
    p = '{32'd10, 32'd8, 32'd9};
    lit = '{32'd0, 32'd1};
    applyStimulus(p, 32'd2, 1'b0);
    waitDone();
    checkJob(lit, 1'b1, 32'd1, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("err_sticky", 64'(Err_Nonmono), 64'd1);

    $display("[TB] reset in the middle of a job");
    p = '{32'd0, 32'd3, 32'd3, 32'd7, 32'd12};
    applyStimulus(p, 32'd4, 1'b0);
    for (int i = 0; i < 100 && got_q.size() < 2; i++) @(posedge clk);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_src_ready", 64'(bus.S_AXIS_ROWPTR_tready), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(bus.M_AXIS_TIMES_tvalid), 64'd0);
    checkOutput("mid_rst_out_data", 64'(bus.M_AXIS_TIMES_tdata), 64'd0);
    checkOutput("mid_rst_busy", 64'(Busy), 64'd0);
    checkOutput("mid_rst_done", 64'(Done), 64'd0);
    checkOutput("mid_rst_err", 64'(Err_Nonmono), 64'd0);
    checkOutput("mid_rst_total", 64'(Total_Nnz), 64'd0);
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("idle_after_rst", 64'(Busy), 64'd0);
    checkOutput("no_out_after_rst", 64'(bus.M_AXIS_TIMES_tvalid), 64'd0);

    $display("[TB] new job after reset");
    p = '{32'd0, 32'd1, 32'd2};
    lit = '{32'd1, 32'd1};
    applyStimulus(p, 32'd2, 1'b0);
    waitDone();
    checkJob(lit, 1'b0, 32'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/row_nnz_gen.md
ROW_NNZ_GEN -- requirements
Module: row_nnz_gen

Interface
REQ-001 Parameter PTR_W, default 32: width of row-pointer and nnz-count data.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-004 Port Start, input, 1: one-cycle job start, sampled only in IDLE.
REQ-005 Port Row_Count, input, 32: rows in job, sampled when Start is accepted; the job consumes Row_Count+1 pointers.
REQ-006 Port S_AXIS_ROWPTR_tdata, input, PTR_W: CSR row-pointer stream.
REQ-007 Port S_AXIS_ROWPTR_tvalid, input, 1.
REQ-008 Port S_AXIS_ROWPTR_tready, output, 1.
REQ-009 Port M_AXIS_TIMES_tdata, output, PTR_W: per-row nnz count, fed to the row kernel TIMES input.
REQ-010 Port M_AXIS_TIMES_tvalid, output, 1.
REQ-011 Port M_AXIS_TIMES_tready, input, 1.
REQ-012 Port Busy, output, 1: high from accepted Start until Done.
REQ-013 Port Done, output, 1: one-cycle pulse at job end.
REQ-014 Port Err_Nonmono, output, 1: sticky flag, set when a pointer decreases.
REQ-015 Port Total_Nnz, output, 32: running sum of emitted counts (see Configuration).

Function
REQ-016 States: IDLE, FIRST, RUN, DRAIN.
REQ-017 IDLE + Start: latch Row_Count, clear Err_Nonmono and Total_Nnz, go to FIRST; Start outside IDLE ignored.
REQ-018 FIRST: tready=1; accepted beat stored as prev, no output; go to RUN if Row_Count!=0, else DRAIN.
REQ-019 RUN: tready = !out_valid | M_AXIS_TIMES_tready.
REQ-020 RUN, accepted beat p: out_data = p-prev, or 0 if p<prev (set Err_Nonmono); prev<=p; remaining-row counter decrements.
REQ-021 Input-to-output latency is exactly 1 cycle; sustained throughput 1 beat/cycle with tready held high.
REQ-022 Output register holds data and tvalid stable until tready; no beat dropped or duplicated.
REQ-023 After the last row beat is accepted, go to DRAIN.
REQ-024 DRAIN: tready=0; once out_valid is low (or goes low this cycle), Done=1 for one cycle, then IDLE.
REQ-025 Subtraction is PTR_W-bit unsigned; wrap-around never reaches the output (clamped per REQ-020).
REQ-026 Row_Count=0xFFFFFFFF is legal; the counter is 32-bit, with no overflow.
REQ-027 Busy = state!=IDLE.

Reset
REQ-028 rstn low forces IDLE at once, regardless of edge; all outputs 0: tready, tvalid, tdata, Busy, Done, Err_Nonmono, Total_Nnz.
REQ-029 Reset mid-job discards the buffered beat and the counters; the next job needs a new Start.

Configuration
REQ-030 Macro ROW_NNZ_TOTAL_EN defined: Total_Nnz adds each emitted count when it is accepted downstream, wrapping at 2^32.
REQ-031 Macro ROW_NNZ_TOTAL_EN undefined: Total_Nnz is tied to 0, no adder is built, and the port list is unchanged.

Structure
REQ-032 The shared package spmv_pkg holds the state enum and the PTR_W default constant.
REQ-033 One sub-module, row_nnz_out_reg: a 1-deep valid/ready output register stage. The FSM and subtract logic stay in the top module.

Verification
REQ-034 Row_Count=4, pointers 0,3,3,7,12, tready=1 -> TIMES 3,0,4,5; Done 1 cycle after the last beat; Total_Nnz=12 with the macro, 0 without.
REQ-035 Same stream, with M_AXIS_TIMES_tready toggling 1010 -> identical output order; tdata stable while stalled; S tready low while the buffer is full and stalled.
REQ-036 Row_Count=0, pointer 5 -> one beat consumed, no TIMES output, Done pulse, Busy low afterwards.
REQ-037 Pointers 10,8,9 with Row_Count=2 -> TIMES 0,1; Err_Nonmono=1 until the next Start.
REQ-038 rstn asserted mid-job after 2 of 4 rows -> outputs 0 immediately; a new Start with 0,1,2 and Row_Count=2 -> TIMES 1,1.
REQ-039 Start pulsed while Busy -> ignored; the current job completes unchanged.
